// File: rtl/iq_stream_sink_fifo_pkg.sv
// Shared sizing constants for the I/Q stream sink FIFO.
// Optional statistics are enabled with the IQ_SINK_FIFO_STATS_EN macro.
package iq_sink_pkg;

    localparam int unsigned DATA_W_DEF       = 32;
    localparam int unsigned DEPTH_LOG2_DEF   = 4;
    localparam int unsigned AFULL_MARGIN_DEF = 4;

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2_DEF;
    localparam int unsigned PTR_W = DEPTH_LOG2_DEF;
    localparam int unsigned CNT_W = DEPTH_LOG2_DEF + 1;

    // Width of the saturating statistics counters
    localparam int unsigned STAT_W = 16;

    // Occupancy at which a lane reports almost-full
    function automatic int unsigned afullThresh(input int unsigned depthLog2,
                                                input int unsigned margin);
        return (2 ** depthLog2) - margin;
    endfunction

endpackage

// File: rtl/iq_stream_sink_fifo_if.sv
// Write-side stream interface between the interpolator (master) and the sink FIFO (slave).
interface iq_stream_sink_fifo_if #(
    parameter int unsigned DATAPATH_WIDTH = 32
) ();

    logic                      Write_enable_i;
    logic [DATAPATH_WIDTH-1:0] data_in_I;
    logic [DATAPATH_WIDTH-1:0] data_in_Q;
    logic                      Afull_I_o;
    logic                      Afull_Q_o;

    modport master (
        output Write_enable_i,
        output data_in_I,
        output data_in_Q,
        input  Afull_I_o,
        input  Afull_Q_o
    );

    modport slave (
        input  Write_enable_i,
        input  data_in_I,
        input  data_in_Q,
        output Afull_I_o,
        output Afull_Q_o
    );

endinterface

// File: rtl/iq_stream_sink_fifo_lane.sv
// Single-lane synchronous FIFO with occupancy count, registered empty/almost-full
// and a registered pop output. Writes are pre-qualified by the parent.
module iq_lane_fifo
    import iq_sink_pkg::*;
#(
    parameter int unsigned WIDTH        = DATA_W_DEF,
    parameter int unsigned DEPTH_LOG2   = DEPTH_LOG2_DEF,
    parameter int unsigned AFULL_MARGIN = AFULL_MARGIN_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wrEn,
    input  logic [WIDTH-1:0]      wrData,
    input  logic                  rdReq,
    output logic [WIDTH-1:0]      rdData,
    output logic                  rdValid,
    output logic                  empty,
    output logic                  afull,
    output logic                  rdEmptyHit,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int unsigned         LANE_DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT  = (DEPTH_LOG2 + 1)'(LANE_DEPTH);
    localparam logic [DEPTH_LOG2:0] AFULL_CNT  =
        (DEPTH_LOG2 + 1)'(afullThresh(DEPTH_LOG2, AFULL_MARGIN));

    logic [WIDTH-1:0]      mem [LANE_DEPTH];
    logic [DEPTH_LOG2-1:0] wrPtr;
    logic [DEPTH_LOG2-1:0] rdPtr;
    logic [DEPTH_LOG2:0]   countNext;
    logic                  full;
    logic                  pop;
    logic                  push;

    assign full       = (count == DEPTH_CNT);
    assign pop        = rdReq && !empty;
    assign push       = wrEn && (!full || pop);
    assign rdEmptyHit = rdReq && empty;

    // Occupancy after this edge; simultaneous push and pop leave it unchanged
    always_comb begin
        countNext = count;
        unique case ({push, pop})
            2'b10:   countNext = count + 1'b1;
            2'b01:   countNext = count - 1'b1;
            default: countNext = count;
        endcase
    end

    // Sample storage, not reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= wrData;
        end
    end

    // Pointers, count, status flags and registered read port
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            count   <= '0;
            empty   <= 1'b1;
            afull   <= 1'b0;
            rdData  <= '0;
            rdValid <= 1'b0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr  <= rdPtr + 1'b1;
                rdData <= mem[rdPtr];
            end
            rdValid <= pop;
            count   <= countNext;
            empty   <= (countNext == '0);
            afull   <= (countNext >= AFULL_CNT);
        end
    end

endmodule

// File: rtl/iq_stream_sink_fifo.sv
// Receive end of the I/Q sample stream: paired write into two lane FIFOs,
// independent reads, sticky overflow/underflow flags.
// Define IQ_SINK_FIFO_STATS_EN to add drop_cnt and max_occ statistics ports.
module iq_stream_sink_fifo
    import iq_sink_pkg::*;
#(
    parameter int unsigned DATAPATH_WIDTH = DATA_W_DEF,
    parameter int unsigned DEPTH_LOG2     = DEPTH_LOG2_DEF,
    parameter int unsigned AFULL_MARGIN   = AFULL_MARGIN_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    iq_stream_sink_fifo_if.slave      strm,
    input  logic                      rd_I,
    input  logic                      rd_Q,
    output logic [DATAPATH_WIDTH-1:0] I_out,
    output logic [DATAPATH_WIDTH-1:0] Q_out,
    output logic                      I_valid,
    output logic                      Q_valid,
    output logic                      empty_I,
    output logic                      empty_Q,
    output logic                      overflow,
    output logic                      underflow,
    input  logic                      clr_flags
`ifdef IQ_SINK_FIFO_STATS_EN
    ,
    output logic [STAT_W-1:0]         drop_cnt,
    output logic [DEPTH_LOG2:0]       max_occ
`endif
);

    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(2 ** DEPTH_LOG2);

    logic                accept;
    logic                dropEvt;
    logic                underEvt;
    logic                canI;
    logic                canQ;
    logic                underI;
    logic                underQ;
    logic [DEPTH_LOG2:0] countI;
    logic [DEPTH_LOG2:0] countQ;

    // A full lane still accepts when it is popped in the same cycle
    assign canI     = (countI != DEPTH_CNT) || rd_I;
    assign canQ     = (countQ != DEPTH_CNT) || rd_Q;
    assign accept   = strm.Write_enable_i && canI && canQ;
    assign dropEvt  = strm.Write_enable_i && !accept;
    assign underEvt = underI || underQ;

    iq_lane_fifo #(
        .WIDTH        (DATAPATH_WIDTH),
        .DEPTH_LOG2   (DEPTH_LOG2),
        .AFULL_MARGIN (AFULL_MARGIN)
    ) u_laneI (
        .clk        (clk),
        .rst        (rst),
        .wrEn       (accept),
        .wrData     (strm.data_in_I),
        .rdReq      (rd_I),
        .rdData     (I_out),
        .rdValid    (I_valid),
        .empty      (empty_I),
        .afull      (strm.Afull_I_o),
        .rdEmptyHit (underI),
        .count      (countI)
    );

    iq_lane_fifo #(
        .WIDTH        (DATAPATH_WIDTH),
        .DEPTH_LOG2   (DEPTH_LOG2),
        .AFULL_MARGIN (AFULL_MARGIN)
    ) u_laneQ (
        .clk        (clk),
        .rst        (rst),
        .wrEn       (accept),
        .wrData     (strm.data_in_Q),
        .rdReq      (rd_Q),
        .rdData     (Q_out),
        .rdValid    (Q_valid),
        .empty      (empty_Q),
        .afull      (strm.Afull_Q_o),
        .rdEmptyHit (underQ),
        .count      (countQ)
    );

    // Sticky error flags; a new event outranks a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (dropEvt) begin
                overflow <= 1'b1;
            end else if (clr_flags) begin
                overflow <= 1'b0;
            end
            if (underEvt) begin
                underflow <= 1'b1;
            end else if (clr_flags) begin
                underflow <= 1'b0;
            end
        end
    end

`ifdef IQ_SINK_FIFO_STATS_EN
    logic [DEPTH_LOG2:0] occNow;

    assign occNow = (countI > countQ) ? countI : countQ;

    // Saturating rejected-write counter; a drop coinciding with a clear counts as the first
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (clr_flags) begin
            drop_cnt <= dropEvt ? STAT_W'(1) : '0;
        end else if (dropEvt && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

    // High-water mark of the larger registered lane occupancy
    always_ff @(posedge clk) begin
        if (rst || clr_flags) begin
            max_occ <= '0;
        end else if (occNow > max_occ) begin
            max_occ <= occNow;
        end
    end
`endif

endmodule

// File: tb/tb_iq_stream_sink_fifo.sv
// Self-checking bench for iq_stream_sink_fifo: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_iq_stream_sink_fifo;
    import iq_sink_pkg::*;

    localparam int unsigned W      = 32;
    localparam int unsigned DL     = 4;
    localparam int unsigned MARGIN = 4;
    localparam int unsigned CAP    = 16;
    localparam int unsigned THRESH = CAP - MARGIN;

    logic         clk = 1'b0;
    logic         rst;
    logic         rd_I;
    logic         rd_Q;
    logic         clr_flags;
    logic [W-1:0] I_out;
    logic [W-1:0] Q_out;
    logic         I_valid;
    logic         Q_valid;
    logic         empty_I;
    logic         empty_Q;
    logic         overflow;
    logic         underflow;
`ifdef IQ_SINK_FIFO_STATS_EN
    logic [15:0]  drop_cnt;
    logic [DL:0]  max_occ;
`endif

    iq_stream_sink_fifo_if #(.DATAPATH_WIDTH(W)) strm ();

    iq_stream_sink_fifo #(
        .DATAPATH_WIDTH (W),
        .DEPTH_LOG2     (DL),
        .AFULL_MARGIN   (MARGIN)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .strm      (strm),
        .rd_I      (rd_I),
        .rd_Q      (rd_Q),
        .I_out     (I_out),
        .Q_out     (Q_out),
        .I_valid   (I_valid),
        .Q_valid   (Q_valid),
        .empty_I   (empty_I),
        .empty_Q   (empty_Q),
        .overflow  (overflow),
        .underflow (underflow),
        .clr_flags (clr_flags)
`ifdef IQ_SINK_FIFO_STATS_EN
        ,
        .drop_cnt  (drop_cnt),
        .max_occ   (max_occ)
`endif
    );

    always #5 clk = ~clk;

    int unsigned errCnt   = 0;
    int unsigned checkCnt = 0;

    // Reference model state
    logic [W-1:0] qI[$];
    logic [W-1:0] qQ[$];
    logic [W-1:0] expI   = '0;
    logic [W-1:0] expQ   = '0;
    bit           expIv  = 1'b0;
    bit           expQv  = 1'b0;
    bit           expOvf = 1'b0;
    bit           expUnf = 1'b0;
    int unsigned  expDrop = 0;
    int unsigned  expMax  = 0;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic checkAll();
        checkVal("I_out",     I_out,     expI);
        checkVal("Q_out",     Q_out,     expQ);
        checkVal("I_valid",   I_valid,   expIv);
        checkVal("Q_valid",   Q_valid,   expQv);
        checkVal("empty_I",   empty_I,   qI.size() == 0);
        checkVal("empty_Q",   empty_Q,   qQ.size() == 0);
        checkVal("Afull_I_o", strm.Afull_I_o, qI.size() >= THRESH);
        checkVal("Afull_Q_o", strm.Afull_Q_o, qQ.size() >= THRESH);
        checkVal("overflow",  overflow,  expOvf);
        checkVal("underflow", underflow, expUnf);
`ifdef IQ_SINK_FIFO_STATS_EN
        checkVal("drop_cnt",  drop_cnt,  expDrop);
        checkVal("max_occ",   max_occ,   expMax);
`endif
    endtask

    // One clock: drive inputs, advance the model at the edge, check shortly after
    task automatic step(input bit we, input logic [W-1:0] dI, input logic [W-1:0] dQ,
                        input bit rI, input bit rQ, input bit clr, input bit r);
        bit          popI;
        bit          popQ;
        bit          acc;
        bit          drop;
        bit          unf;
        int unsigned occBefore;
        @(negedge clk);
        strm.Write_enable_i = we;
        strm.data_in_I      = dI;
        strm.data_in_Q      = dQ;
        rd_I                = rI;
        rd_Q                = rQ;
        clr_flags           = clr;
        rst                 = r;
        @(posedge clk);
        if (r) begin
            qI.delete();
            qQ.delete();
            expI = '0; expQ = '0; expIv = 0; expQv = 0;
            expOvf = 0; expUnf = 0; expDrop = 0; expMax = 0;
        end else begin
            occBefore = (qI.size() > qQ.size()) ? qI.size() : qQ.size();
            popI = rI && (qI.size() > 0);
            popQ = rQ && (qQ.size() > 0);
            unf  = (rI && !popI) || (rQ && !popQ);
            acc  = we && ((qI.size() < CAP) || rI) && ((qQ.size() < CAP) || rQ);
            drop = we && !acc;
            expIv = popI;
            expQv = popQ;
            if (popI) expI = qI.pop_front();
            if (popQ) expQ = qQ.pop_front();
            if (acc) begin
                qI.push_back(dI);
                qQ.push_back(dQ);
            end
            if (drop) expOvf = 1; else if (clr) expOvf = 0;
            if (unf)  expUnf = 1; else if (clr) expUnf = 0;
            if (clr) begin
                expDrop = drop ? 1 : 0;
                expMax  = 0;
            end else begin
                if (drop && expDrop < 65535) expDrop++;
                if (occBefore > expMax) expMax = occBefore;
            end
        end
        #1;
        checkAll();
    endtask

    initial begin
        strm.Write_enable_i = 0;
        strm.data_in_I = '0;
        strm.data_in_Q = '0;
        rd_I = 0; rd_Q = 0; clr_flags = 0; rst = 1;

        // Reset state
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);

        // Almost-full threshold crossing
        for (int unsigned k = 0; k < 12; k++) begin
            step(1, k, 32'h100 + k, 0, 0, 0, 0);
            if (k == 10) checkVal("afull_after11", strm.Afull_I_o, 1'b0);
        end
        checkVal("afull_after12_I", strm.Afull_I_o, 1'b1);
        checkVal("afull_after12_Q", strm.Afull_Q_o, 1'b1);

        // Fill to 16, then a rejected 17th write
        for (int unsigned k = 12; k < 16; k++) step(1, k, 32'h100 + k, 0, 0, 0, 0);
        step(1, 32'hDEAD, 32'hBEEF, 0, 0, 0, 0);
        checkVal("ovf_on_full", overflow, 1'b1);
`ifdef IQ_SINK_FIFO_STATS_EN
        step(0, 0, 0, 0, 0, 0, 0);
        checkVal("drop_cnt_1", drop_cnt, 16'd1);
        checkVal("max_occ_16", max_occ, 16);
`endif

        // Full lanes popped while writing: write accepted, first sample out
        step(1, 32'h55, 32'h155, 1, 1, 0, 0);
        checkVal("full_rw_I_out", I_out, 32'd0);
        checkVal("full_rw_I_valid", I_valid, 1'b1);
        checkVal("full_rw_count", qI.size(), CAP);

        // Three pairs, uneven draining, then underflow on I
        step(0, 0, 0, 0, 0, 0, 1);
        for (int unsigned k = 0; k < 3; k++) step(1, k, 32'h100 + k, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0);
        checkVal("q_first", Q_out, 32'h100);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        checkVal("i_third", I_out, 32'd2);
        checkVal("i_empty", empty_I, 1'b1);
        step(0, 0, 0, 1, 0, 0, 0);
        checkVal("unf_set", underflow, 1'b1);
        checkVal("unf_no_valid", I_valid, 1'b0);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, 1, 0);
        checkVal("unf_beats_clr", underflow, 1'b1);

        // Pointer wrap at steady occupancy of 5
        step(0, 0, 0, 0, 0, 0, 1);
        for (int unsigned k = 0; k < 5; k++) step(1, 32'h1000 + k, 32'h2000 + k, 0, 0, 0, 0);
        for (int unsigned k = 5; k < 45; k++) step(1, 32'h1000 + k, 32'h2000 + k, 1, 1, 0, 0);
        for (int unsigned k = 0; k < 6; k++) step(0, 0, 0, 1, 1, 0, 0);

        // Mid-stream reset discards buffered data
        step(0, 0, 0, 0, 0, 0, 1);
        for (int unsigned k = 0; k < 7; k++) step(1, 32'h300 + k, 32'h400 + k, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(1, 32'hAAAA, 32'hBBBB, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0);
        checkVal("post_rst_I", I_out, 32'hAAAA);
        checkVal("post_rst_Q", Q_out, 32'hBBBB);

        // Randomized traffic
        for (int unsigned n = 0; n < 3000; n++) begin
            step(($urandom_range(99) < 60), $urandom, $urandom,
                 ($urandom_range(99) < 45), ($urandom_range(99) < 45),
                 ($urandom_range(99) < 5), ($urandom_range(999) < 8));
        end

        $display("Result: errors=%0d of %0d checks", errCnt, checkCnt);
        $finish;
    end

endmodule
